// File: rtl/rangefinder_sopc_cpu_oci_dct_packer_if.sv
// Trace-symbol in / frame out bundle for the OCI DCT packer, plus the
// live accumulator and drop-status taps.
interface rangefinder_sopc_cpu_oci_dct_packer_if #(
  parameter int unsigned SLOTS  = 15,
  parameter int unsigned DROP_W = 8
);
  localparam int unsigned AccW = 2 * SLOTS;
  localparam int unsigned CntW = $clog2(SLOTS + 1);

  logic              sym_valid;
  logic [1:0]        sym_data;
  logic              flush;
  logic              frame_ready;
  logic              frame_valid;
  logic [AccW-1:0]   frame_data;
  logic [CntW-1:0]   frame_count;
  logic [AccW-1:0]   dct_buffer;
  logic [CntW-1:0]   dct_count;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  modport master (
    output sym_valid, sym_data, flush, frame_ready,
    input  frame_valid, frame_data, frame_count, dct_buffer, dct_count, overflow, drop_count
  );

  modport slave (
    input  sym_valid, sym_data, flush, frame_ready,
    output frame_valid, frame_data, frame_count, dct_buffer, dct_count, overflow, drop_count
  );
endinterface

// File: rtl/rangefinder_sopc_cpu_oci_dct_packer.sv
// Packs 2-bit trace symbols into SLOTS-symbol frames held in a one-entry
// output register; flush emits a partial frame, blocked symbols are counted.
module rangefinder_sopc_cpu_oci_dct_packer #(
  parameter int unsigned SLOTS  = 15,
  parameter int unsigned DROP_W = 8
) (
  input logic clk,
  input logic reset,
  rangefinder_sopc_cpu_oci_dct_packer_if.slave bus
);
  localparam int unsigned AccW = 2 * SLOTS;
  localparam int unsigned CntW = $clog2(SLOTS + 1);
  localparam logic [CntW-1:0] Full = CntW'(SLOTS);

  logic [AccW-1:0]   r_acc, w_acc_d;
  logic [CntW-1:0]   r_acc_count, w_acc_count_d;
  logic              r_flush_pend, w_flush_pend_d;
  logic              r_frame_valid, w_frame_valid_d;
  logic [AccW-1:0]   r_frame_data, w_frame_data_d;
  logic [CntW-1:0]   r_frame_count, w_frame_count_d;
  logic              r_overflow, w_overflow_d;
  logic [DROP_W-1:0] r_drop_count, w_drop_count_d;

  logic w_out_free, w_acc_full, w_acc_nonempty, w_transfer, w_accept, w_drop;

  // Transfer depends only on registered state, so it never waits on this cycle's symbol.
  assign w_out_free     = ~r_frame_valid | bus.frame_ready;
  assign w_acc_full     = (r_acc_count == Full);
  assign w_acc_nonempty = (r_acc_count != '0);
  assign w_transfer     = w_out_free & (w_acc_full | (r_flush_pend & w_acc_nonempty));
  assign w_accept       = bus.sym_valid & (~w_acc_full | w_transfer);
  assign w_drop         = bus.sym_valid & ~w_accept;

  always_comb begin
    w_acc_d         = r_acc;
    w_acc_count_d   = r_acc_count;
    w_frame_valid_d = r_frame_valid;
    w_frame_data_d  = r_frame_data;
    w_frame_count_d = r_frame_count;
    w_overflow_d    = r_overflow;
    w_drop_count_d  = r_drop_count;
    w_flush_pend_d  = bus.flush | (r_flush_pend & ~w_transfer & w_acc_nonempty);

    if (w_transfer) begin
      w_frame_valid_d = 1'b1;
      w_frame_data_d  = r_acc;
      w_frame_count_d = r_acc_count;
      w_acc_d         = '0;
      w_acc_count_d   = '0;
      if (w_accept) begin
        w_acc_d[1:0]  = bus.sym_data;
        w_acc_count_d = CntW'(1);
      end
    end else begin
      if (r_frame_valid && bus.frame_ready) begin
        w_frame_valid_d = 1'b0;
      end
      if (w_accept) begin
        for (int k = 0; k < int'(SLOTS); k++) begin
          if (r_acc_count == CntW'(k)) begin
            w_acc_d[2*k +: 2] = bus.sym_data;
          end
        end
        w_acc_count_d = r_acc_count + CntW'(1);
      end
    end

    if (w_drop) begin
      w_overflow_d = 1'b1;
      if (r_drop_count != '1) begin
        w_drop_count_d = r_drop_count + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc         <= '0;
      r_acc_count   <= '0;
      r_flush_pend  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_data  <= '0;
      r_frame_count <= '0;
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_acc         <= w_acc_d;
      r_acc_count   <= w_acc_count_d;
      r_flush_pend  <= w_flush_pend_d;
      r_frame_valid <= w_frame_valid_d;
      r_frame_data  <= w_frame_data_d;
      r_frame_count <= w_frame_count_d;
      r_overflow    <= w_overflow_d;
      r_drop_count  <= w_drop_count_d;
    end
  end

  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_data  = r_frame_data;
  assign bus.frame_count = r_frame_count;
  assign bus.dct_buffer  = r_acc;
  assign bus.dct_count   = r_acc_count;
  assign bus.overflow    = r_overflow;
  assign bus.drop_count  = r_drop_count;
endmodule

// File: tb/tb_rangefinder_sopc_cpu_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: stimulus queues expected frames,
// a negedge monitor pops and compares on every frame handshake.
module tb_rangefinder_sopc_cpu_oci_dct_packer;
  typedef struct packed {
    logic [29:0] data;
    logic [3:0]  count;
  } frame_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   frames_seen = 0;
  frame_t sb_q[$];

  rangefinder_sopc_cpu_oci_dct_packer_if #(.SLOTS(15), .DROP_W(8)) bus ();

  rangefinder_sopc_cpu_oci_dct_packer #(.SLOTS(15), .DROP_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on handshake, and checks hold-stability while back-pressured.
  logic        hold_prev = 1'b0;
  logic [29:0] prev_data;
  logic [3:0]  prev_count;
  frame_t      exp_f;
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_data", 32'(bus.frame_data), 32'(prev_data));
        check("hold_count", 32'(bus.frame_count), 32'(prev_count));
      end
      if (bus.frame_valid && bus.frame_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected actual=%h/%0d required=none", bus.frame_data,
                   bus.frame_count);
        end else begin
          exp_f = sb_q.pop_front();
          check("frame_data", 32'(bus.frame_data), 32'(exp_f.data));
          check("frame_count", 32'(bus.frame_count), 32'(exp_f.count));
          frames_seen++;
        end
      end
      hold_prev  = bus.frame_valid & ~bus.frame_ready;
      prev_data  = bus.frame_data;
      prev_count = bus.frame_count;
    end
  end

  task automatic drive(input logic v, input logic [1:0] d, input logic f);
    bus.sym_valid = v;
    bus.sym_data  = d;
    bus.flush     = f;
    @(posedge clk);
    #1;
    bus.sym_valid = 1'b0;
    bus.sym_data  = 2'b00;
    bus.flush     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int base;
  initial begin
    reset           = 1'b1;
    bus.sym_valid   = 1'b0;
    bus.sym_data    = 2'b00;
    bus.flush       = 1'b0;
    bus.frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_frame_valid", 32'(bus.frame_valid), 0);
    check("rst_frame_data", 32'(bus.frame_data), 0);
    check("rst_frame_count", 32'(bus.frame_count), 0);
    check("rst_dct_count", 32'(bus.dct_count), 0);
    check("rst_dct_buffer", 32'(bus.dct_buffer), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_drop_count", 32'(bus.drop_count), 0);

    // Full frame of 0,1,2,3,...
    bus.frame_ready = 1'b1;
    sb_q.push_back('{30'h24E4E4E4, 4'd15});
    for (int i = 0; i < 15; i++) drive(1'b1, 2'(i % 4), 1'b0);
    check("full_dct_count", 32'(bus.dct_count), 15);
    check("full_dct_buffer", 32'(bus.dct_buffer), 32'h24E4E4E4);
    check("full_valid_n", 32'(bus.frame_valid), 0);
    idle(1);
    check("full_valid_n1", 32'(bus.frame_valid), 1);
    check("full_dct_empty", 32'(bus.dct_count), 0);
    check("full_buf_empty", 32'(bus.dct_buffer), 0);
    idle(1);

    // Partial frame via flush
    sb_q.push_back('{30'h0000001B, 4'd3});
    drive(1'b1, 2'd3, 1'b0);
    drive(1'b1, 2'd2, 1'b0);
    drive(1'b1, 2'd1, 1'b0);
    drive(1'b0, 2'd0, 1'b1);
    check("flush_valid_n1", 32'(bus.frame_valid), 0);
    idle(1);
    check("flush_valid_n2", 32'(bus.frame_valid), 1);
    check("flush_count", 32'(bus.frame_count), 3);
    idle(1);
    check("flush_dct_empty", 32'(bus.dct_count), 0);

    // Back-pressure: 31 symbols, last one dropped
    bus.frame_ready = 1'b0;
    sb_q.push_back('{30'h15555555, 4'd15});
    sb_q.push_back('{30'h2AAAAAAA, 4'd15});
    for (int i = 0; i < 15; i++) drive(1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 15; i++) drive(1'b1, 2'd2, 1'b0);
    check("bp_no_overflow_yet", 32'(bus.overflow), 0);
    drive(1'b1, 2'd3, 1'b0);
    check("bp_overflow", 32'(bus.overflow), 1);
    check("bp_drop_count", 32'(bus.drop_count), 1);
    check("bp_dct_count", 32'(bus.dct_count), 15);
    check("bp_dct_buffer", 32'(bus.dct_buffer), 32'h2AAAAAAA);
    check("bp_held_valid", 32'(bus.frame_valid), 1);
    check("bp_held_data", 32'(bus.frame_data), 32'h15555555);
    bus.frame_ready = 1'b1;
    idle(1);
    check("bp_second_valid", 32'(bus.frame_valid), 1);
    check("bp_second_data", 32'(bus.frame_data), 32'h2AAAAAAA);
    idle(2);
    check("bp_drained", 32'(bus.frame_valid), 0);
    check("bp_sb_empty", 32'(sb_q.size()), 0);

    // Continuous 45 symbols at full rate
    do_reset();
    base = frames_seen;
    sb_q.push_back('{30'h24E4E4E4, 4'd15});
    sb_q.push_back('{30'h13939393, 4'd15});
    sb_q.push_back('{30'h0E4E4E4E, 4'd15});
    for (int i = 0; i < 45; i++) drive(1'b1, 2'(i % 4), 1'b0);
    idle(2);
    check("stream_frames", 32'(frames_seen - base), 3);
    check("stream_drops", 32'(bus.drop_count), 0);
    check("stream_overflow", 32'(bus.overflow), 0);

    // Empty flush, then saturating drops
    drive(1'b0, 2'd0, 1'b1);
    check("eflush_n1", 32'(bus.frame_valid), 0);
    idle(1);
    check("eflush_n2", 32'(bus.frame_valid), 0);
    idle(1);
    check("eflush_n3", 32'(bus.frame_valid), 0);
    bus.frame_ready = 1'b0;
    sb_q.push_back('{30'h0, 4'd15});
    sb_q.push_back('{30'h0, 4'd15});
    for (int i = 0; i < 330; i++) begin
      drive(1'b1, 2'd0, 1'b0);
      if (i == 283) check("sat_fe", 32'(bus.drop_count), 32'hFE);
      if (i == 284) check("sat_ff", 32'(bus.drop_count), 32'hFF);
    end
    check("sat_hold", 32'(bus.drop_count), 32'hFF);
    check("sat_overflow", 32'(bus.overflow), 1);
    bus.frame_ready = 1'b1;
    idle(3);
    check("sat_sb_empty", 32'(sb_q.size()), 0);

    // Reset mid-frame with a pending frame, dominating all inputs
    do_reset();
    bus.frame_ready = 1'b0;
    for (int i = 0; i < 22; i++) drive(1'b1, 2'd3, 1'b0);
    check("mid_pre_count", 32'(bus.dct_count), 7);
    check("mid_pre_valid", 32'(bus.frame_valid), 1);
    bus.frame_ready = 1'b1;
    reset = 1'b1;
    drive(1'b1, 2'd2, 1'b1);
    reset = 1'b0;
    check("mid_frame_valid", 32'(bus.frame_valid), 0);
    check("mid_frame_data", 32'(bus.frame_data), 0);
    check("mid_frame_count", 32'(bus.frame_count), 0);
    check("mid_dct_count", 32'(bus.dct_count), 0);
    check("mid_dct_buffer", 32'(bus.dct_buffer), 0);
    check("mid_overflow", 32'(bus.overflow), 0);
    check("mid_drop_count", 32'(bus.drop_count), 0);
    drive(1'b0, 2'd0, 1'b1);
    check("mid_flush_n1", 32'(bus.frame_valid), 0);
    idle(1);
    check("mid_flush_n2", 32'(bus.frame_valid), 0);
    idle(1);
    check("mid_flush_n3", 32'(bus.frame_valid), 0);
    check("final_sb_empty", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
